// File: rtl/rf_wb_arbiter.sv
// Register-file write-port arbiter: in-order writeback beats buffered long-latency results.
// Optional perf counters behind RF_ARB_PERF_EN.
module rf_wb_arbiter #(
  parameter int unsigned FifoDepth = 2,
  parameter int unsigned StarveMax = 4
) (
  input  logic        clk_i,
  input  logic        rst_ni,
`ifdef RF_ARB_PERF_EN
  output logic [31:0] perf_conflicts_o,
  output logic [15:0] perf_forces_o,
`endif
  input  logic        wb_valid_i,
  input  logic        wb_wen_i,
  input  logic [4:0]  wb_rd_i,
  input  logic [31:0] wb_data_i,
  input  logic        lu_valid_i,
  output logic        lu_ready_o,
  input  logic [4:0]  lu_rd_i,
  input  logic [31:0] lu_data_i,
  input  logic        sb_set_i,
  input  logic [4:0]  sb_set_rd_i,
  output logic [31:0] sb_busy_o,
  output logic        stall_req_o,
  output logic        rf_wen_o,
  output logic [4:0]  rf_waddr_o,
  output logic [31:0] rf_wdata_o
);

  localparam int unsigned PtrW = (FifoDepth > 1) ? $clog2(FifoDepth) : 1;
  localparam int unsigned CntW = PtrW + 1;

  typedef enum logic [0:0] {StIdle, StForce} state_e;

  state_e            state_q;
  logic [3:0]        starve_q;
  logic              stall_req_q;
  logic [4:0]        rd_mem_q   [FifoDepth];
  logic [31:0]       data_mem_q [FifoDepth];
  logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]   count_q, count_d;
  logic [31:0]       sb_busy_q, sb_busy_d, clr_mask, set_mask;
  logic              rf_wen_q;
  logic [4:0]        rf_waddr_q, rf_waddr_d;
  logic [31:0]       rf_wdata_q, rf_wdata_d;
  logic              wb_req, fifo_empty, fifo_full, pop, push, conflict, force_enter;

  assign wb_req     = wb_valid_i & wb_wen_i & (wb_rd_i != 5'd0);
  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == CntW'(FifoDepth));
  assign pop        = ~wb_req & ~fifo_empty;
  // A pop in the same cycle frees a slot, so a full FIFO can still take a result.
  assign lu_ready_o = ~fifo_full | pop;
  assign push       = lu_valid_i & lu_ready_o & (lu_rd_i != 5'd0);
  assign conflict   = wb_req & ~fifo_empty;
  assign force_enter = (state_q == StIdle) & conflict & (starve_q == 4'(StarveMax - 1));

  always_comb begin
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + CntW'(1);
    end else if (pop && !push) begin
      count_d = count_q - CntW'(1);
    end
  end

  // Set is applied after clear so a same-cycle set of the popped rd wins.
  always_comb begin
    clr_mask  = pop ? (32'd1 << rd_mem_q[rd_ptr_q]) : 32'd0;
    set_mask  = (sb_set_i && (sb_set_rd_i != 5'd0)) ? (32'd1 << sb_set_rd_i) : 32'd0;
    sb_busy_d = ((sb_busy_q & ~clr_mask) | set_mask) & ~32'd1;
  end

  always_comb begin
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    if (wb_req) begin
      rf_waddr_d = wb_rd_i;
      rf_wdata_d = wb_data_i;
    end else if (pop) begin
      rf_waddr_d = rd_mem_q[rd_ptr_q];
      rf_wdata_d = data_mem_q[rd_ptr_q];
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      rd_mem_q[wr_ptr_q]   <= lu_rd_i;
      data_mem_q[wr_ptr_q] <= lu_data_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      sb_busy_q  <= '0;
      rf_wen_q   <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      count_q    <= count_d;
      sb_busy_q  <= sb_busy_d;
      rf_wen_q   <= wb_req | pop;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      starve_q    <= '0;
      stall_req_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (pop) begin
            starve_q <= '0;
          end else if (force_enter) begin
            starve_q    <= 4'(StarveMax);
            state_q     <= StForce;
            stall_req_q <= 1'b1;
          end else if (conflict) begin
            starve_q <= starve_q + 4'd1;
          end
        end
        StForce: begin
          if (pop) begin
            starve_q    <= '0;
            state_q     <= StIdle;
            stall_req_q <= 1'b0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

`ifdef RF_ARB_PERF_EN
  logic [31:0] perf_conflicts_q;
  logic [15:0] perf_forces_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      perf_conflicts_q <= '0;
      perf_forces_q    <= '0;
    end else begin
      if (conflict && (perf_conflicts_q != '1)) perf_conflicts_q <= perf_conflicts_q + 32'd1;
      if (force_enter && (perf_forces_q != '1)) perf_forces_q <= perf_forces_q + 16'd1;
    end
  end

  assign perf_conflicts_o = perf_conflicts_q;
  assign perf_forces_o    = perf_forces_q;
`endif

  assign sb_busy_o   = sb_busy_q;
  assign stall_req_o = stall_req_q;
  assign rf_wen_o    = rf_wen_q;
  assign rf_waddr_o  = rf_waddr_q;
  assign rf_wdata_o  = rf_wdata_q;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Bench for rf_wb_arbiter: directed steps plus random traffic against a queue-based model.
module tb_rf_wb_arbiter;

  localparam int unsigned Depth  = 2;
  localparam int unsigned Starve = 4;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } ent_t;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        wb_valid, wb_wen, lu_valid, sb_set;
  logic [4:0]  wb_rd, lu_rd, sb_set_rd;
  logic [31:0] wb_data, lu_data;
  logic        lu_ready_o, stall_req_o, rf_wen_o;
  logic [31:0] sb_busy_o, rf_wdata_o;
  logic [4:0]  rf_waddr_o;
`ifdef RF_ARB_PERF_EN
  logic [31:0] perf_conflicts_o;
  logic [15:0] perf_forces_o;
`endif

  int vectors = 0;
  int miscompares = 0;

  // Reference model state.
  ent_t        q[$];
  logic [31:0] m_busy;
  int          m_starve;
  bit          m_force;
  logic        m_wen;
  logic [4:0]  m_waddr;
  logic [31:0] m_wdata;
  logic [31:0] m_conf;
  logic [15:0] m_forces;

  rf_wb_arbiter #(
    .FifoDepth(Depth),
    .StarveMax(Starve)
  ) dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
`ifdef RF_ARB_PERF_EN
    .perf_conflicts_o(perf_conflicts_o),
    .perf_forces_o   (perf_forces_o),
`endif
    .wb_valid_i (wb_valid),
    .wb_wen_i   (wb_wen),
    .wb_rd_i    (wb_rd),
    .wb_data_i  (wb_data),
    .lu_valid_i (lu_valid),
    .lu_ready_o (lu_ready_o),
    .lu_rd_i    (lu_rd),
    .lu_data_i  (lu_data),
    .sb_set_i   (sb_set),
    .sb_set_rd_i(sb_set_rd),
    .sb_busy_o  (sb_busy_o),
    .stall_req_o(stall_req_o),
    .rf_wen_o   (rf_wen_o),
    .rf_waddr_o (rf_waddr_o),
    .rf_wdata_o (rf_wdata_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_busy = '0; m_starve = 0; m_force = 0;
    m_wen = 0; m_waddr = '0; m_wdata = '0;
    m_conf = '0; m_forces = '0;
  endtask

  task automatic check_outputs(input string pfx);
    check({pfx, "_rf_wen"},   32'(rf_wen_o),    32'(m_wen));
    check({pfx, "_rf_waddr"}, 32'(rf_waddr_o),  32'(m_waddr));
    check({pfx, "_rf_wdata"}, rf_wdata_o,       m_wdata);
    check({pfx, "_sb_busy"},  sb_busy_o,        m_busy);
    check({pfx, "_stall"},    32'(stall_req_o), 32'(m_force));
`ifdef RF_ARB_PERF_EN
    check({pfx, "_perf_conf"},   perf_conflicts_o,    m_conf);
    check({pfx, "_perf_forces"}, 32'(perf_forces_o),  32'(m_forces));
`endif
  endtask

  task automatic idle_in();
    wb_valid = 0; wb_wen = 0; wb_rd = '0; wb_data = '0;
    lu_valid = 0; lu_rd = '0; lu_data = '0;
    sb_set = 0; sb_set_rd = '0;
  endtask

  task automatic wb_in(input logic [4:0] rd, input logic [31:0] d);
    wb_valid = 1; wb_wen = 1; wb_rd = rd; wb_data = d;
  endtask

  task automatic lu_in(input logic [4:0] rd, input logic [31:0] d);
    lu_valid = 1; lu_rd = rd; lu_data = d;
  endtask

  // Called just after a falling edge with inputs already driven.
  task automatic cycle();
    bit   wbreq, popm, ready;
    int   sz;
    ent_t h, e;
    #1;
    wbreq = wb_valid && wb_wen && (wb_rd != 5'd0);
    sz    = q.size();
    popm  = !wbreq && (sz > 0);
    ready = (sz < Depth) || popm;
    check("lu_ready", 32'(lu_ready_o), 32'(ready));
    if (wbreq && sz > 0 && m_conf != 32'hFFFF_FFFF) m_conf++;
    if (popm) begin
      h = q.pop_front();
      m_busy[h.rd] = 1'b0;
      m_wen = 1; m_waddr = h.rd; m_wdata = h.data;
    end else if (wbreq) begin
      m_wen = 1; m_waddr = wb_rd; m_wdata = wb_data;
    end else begin
      m_wen = 0;
    end
    if (sb_set && sb_set_rd != 5'd0) m_busy[sb_set_rd] = 1'b1;
    if (lu_valid && ready && lu_rd != 5'd0) begin
      e.rd = lu_rd; e.data = lu_data;
      q.push_back(e);
    end
    if (!m_force) begin
      if (popm) m_starve = 0;
      else if (wbreq && sz > 0) begin
        m_starve++;
        if (m_starve >= Starve) begin
          m_force = 1;
          if (m_forces != 16'hFFFF) m_forces++;
        end
      end
    end else if (popm) begin
      m_force = 0; m_starve = 0;
    end
    @(posedge clk_i);
    #1;
    check_outputs("cyc");
    @(negedge clk_i);
  endtask

  initial begin
    rst_ni = 0;
    idle_in();
    model_reset();
    #1;
    check("reset_lu_ready", 32'(lu_ready_o), 32'd1);
    check_outputs("reset");
    @(negedge clk_i);
    rst_ni = 1;

    // Writeback only.
    wb_in(5'd5, 32'h1234);
    cycle();
    check("wb_only_addr", 32'(rf_waddr_o), 32'd5);
    check("wb_only_data", rf_wdata_o, 32'h1234);
    idle_in();
    cycle();

    // Long-latency only.
    sb_set = 1; sb_set_rd = 5'd7;
    cycle();
    idle_in();
    check("lu_busy7", 32'(sb_busy_o[7]), 32'd1);
    lu_in(5'd7, 32'hAA);
    cycle();
    idle_in();
    cycle();
    check("lu_write_addr", 32'(rf_waddr_o), 32'd7);
    check("lu_busy7_clr", 32'(sb_busy_o[7]), 32'd0);
    cycle();

    // Conflict and forced stall.
    wb_in(5'd3, 32'h3333);
    lu_in(5'd9, 32'h9999);
    cycle();
    lu_valid = 0;
    for (int i = 0; i < 5; i++) cycle();
    check("conflict_stall", 32'(stall_req_o), 32'd1);
    idle_in();
    cycle();
    check("conflict_pop_addr", 32'(rf_waddr_o), 32'd9);
    cycle();
    check("conflict_stall_fall", 32'(stall_req_o), 32'd0);

    // Full FIFO with a held third result.
    wb_in(5'd3, 32'h3);
    lu_in(5'd10, 32'hA0);
    cycle();
    lu_in(5'd11, 32'hB0);
    cycle();
    lu_in(5'd12, 32'hC0);
    #1 check("full_ready_low", 32'(lu_ready_o), 32'd0);
    cycle();
    cycle();
    wb_valid = 0;
    #1 check("full_pop_push_ready", 32'(lu_ready_o), 32'd1);
    cycle();
    lu_valid = 0;
    for (int i = 0; i < 4; i++) cycle();

    // Set/clear collision.
    idle_in();
    sb_set = 1; sb_set_rd = 5'd4;
    cycle();
    idle_in();
    lu_in(5'd4, 32'h44);
    cycle();
    idle_in();
    sb_set = 1; sb_set_rd = 5'd4;
    cycle();
    check("collision_busy4", 32'(sb_busy_o[4]), 32'd1);
    idle_in();
    cycle();

    // Random traffic.
    for (int n = 0; n < 400; n++) begin
      wb_valid  = ($urandom_range(0, 9) < 6);
      wb_wen    = ($urandom_range(0, 9) < 8);
      wb_rd     = 5'($urandom);
      wb_data   = $urandom;
      lu_valid  = $urandom_range(0, 1) == 1;
      lu_rd     = 5'($urandom);
      lu_data   = $urandom;
      sb_set    = $urandom_range(0, 2) == 0;
      sb_set_rd = 5'($urandom);
      cycle();
    end
    idle_in();
    for (int i = 0; i < 4; i++) cycle();

    // Reset while the FIFO holds two results.
    wb_in(5'd2, 32'h22);
    lu_in(5'd20, 32'h20);
    cycle();
    lu_in(5'd21, 32'h21);
    cycle();
    idle_in();
    wb_in(5'd2, 32'h22);
    rst_ni = 0;
    model_reset();
    #1;
    check("midrst_lu_ready", 32'(lu_ready_o), 32'd1);
    check_outputs("midrst");
    @(negedge clk_i);
    idle_in();
    rst_ni = 1;
    for (int i = 0; i < 3; i++) cycle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
